player_mover: RTL
=================

Name: player_mover

Overview:
- Multi-player successor to the single-centre key controller; drives the sprite positions for the game renderer.
- Updates NPLAYERS positions once per vertical blanking, every FRAMES_PER_STEP frames.
- Clamps each position so the whole sprite stays on screen.
- Consults an external collision checker through a req/ack handshake before committing any move; blocked diagonals slide along one free axis.

Parameters:
NPLAYERS, 2, number of players (1..4)
CW, 11, signed coordinate width
HACTIVE, 800, visible width in pixels
VACTIVE, 600, visible height in pixels
SPRITE_W, 32, sprite width; XMAX = HACTIVE-SPRITE_W
SPRITE_H, 32, sprite height; YMAX = VACTIVE-SPRITE_H
STEP, 1, pixels per move per axis
FRAMES_PER_STEP, 1, blanking periods between update passes (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
SOF  in  1  start-of-frame pulse
EOF  in  1  end-of-frame pulse
key  in  4*NPLAYERS  active-low keys per player p at [4p+3:4p]; bit0 right, bit1 down, bit2 up, bit3 left
centerX  out  CW*NPLAYERS  signed X of player p at [CW*p +: CW]
centerY  out  CW*NPLAYERS  signed Y of player p
query_req  out  1  collision query valid
query_x  out  CW  candidate X
query_y  out  CW  candidate Y
query_id  out  2  player under query
query_ack  in  1  checker response valid (one cycle)
query_blocked  in  1  candidate blocked; sampled with query_ack
pass_overrun  out  1  one-cycle pulse when SOF truncates a pass

Behaviour:
- Reset: blank=0, frame_cnt=0, FSM IDLE, query_req=0, query_x/y/id=0, pass_overrun=0.
- Reset start positions (corners): X = (p even) ? 0 : XMAX; Y = (p<2) ? 0 : YMAX.
- blank flag: set on EOF, cleared on SOF; SOF wins if both are high in the same cycle.
- frame_cnt increments on each EOF and wraps at FRAMES_PER_STEP-1. A pass starts the cycle after the EOF on which frame_cnt wraps.
- States: IDLE -> DECODE -> (QUERY -> WAIT_ACK)* -> COMMIT -> NEXT -> DECODE or IDLE. Players are processed in order 0..NPLAYERS-1, one per pass slot.
- DECODE, key decoding:
  - key sampled once, in DECODE. dx = +STEP (right), -STEP (left), 0 if both or neither; dy likewise (down +, up -).
  - Target = position + (dx,dy), each axis saturated to [0,XMAX] / [0,YMAX]. Never -1 or beyond the max.
  - If target equals the current position, skip straight to NEXT; no query is issued.
- Handshake:
  - In QUERY, assert query_req with stable query_x/y/id.
  - Hold all four until the cycle query_ack=1; drop query_req the following cycle.
  - query_ack while query_req=0 is ignored. Checker latency is unbounded.
- Blocked candidate:
  - Diagonal candidate blocked: retry (targetX, curY), then (curX, targetY). The first free candidate is committed.
  - Straight candidate blocked: no move.
  - At most 3 queries per player per pass.
- COMMIT writes both coordinates of that player in one cycle. Other players' outputs are untouched.
- Positions change only while blank=1.
- SOF mid-pass:
  - No further commits occur.
  - If in WAIT_ACK, wait for the ack and discard the result.
  - Then return to IDLE, pulse pass_overrun for one cycle, and leave the remaining players unmoved this frame.
- EOF during an active pass has no effect on the FSM.
- Asynchronous reset mid-pass: immediate return to the reset values, including query_req=0.

Decomposition:
- Shared package bomber_pkg holds:
  - HACTIVE, VACTIVE and the key bit index constants KEY_RIGHT/DOWN/UP/LEFT.
  - The mover state enum typedef.
  - The coord_t signed [CW-1:0] typedef.
- Natural sub-module: move_target. It is combinational: key nibble + current X/Y -> saturated target X/Y plus a diagonal flag. It is instantiated once and muxed by player index.

Test Plan:
- Reset, NPLAYERS=2 -> P0=(0,0), P1=(768,0); query_req=0.
- P0 key=4'b1110, checker always free, one EOF -> exactly one query at (1,0); after ack P0=(1,0), stable through the active frame.
- P0 at (0,0), key=4'b0111 (left) -> no query issued, P0 stays (0,0); P1 at X=768, key right -> no query.
- P0 at (10,10), key=4'b1100, checker blocks only (11,11) -> queries (11,11) then (11,10); final P0=(11,10).
- FRAMES_PER_STEP=3, key held right for 6 EOFs -> P0.X advances by exactly 2.
- Checker delays ack past SOF -> no commit, pass_overrun pulses once, P1 unchanged; next pass processes normally.

Source files
------------

// File: rtl/bomber_pkg.sv
// Shared definitions for the sprite movement logic: screen geometry,
// key bit positions, coordinate type and the mover FSM state encoding.
package bomber_pkg;

    localparam int HACTIVE = 800;
    localparam int VACTIVE = 600;
    localparam int COORD_W = 11;

    // Key nibble bit positions (keys are active-low)
    localparam int unsigned KEY_RIGHT = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_LEFT  = 3;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_QUERY,
        ST_WAIT_ACK,
        ST_COMMIT,
        ST_NEXT
    } mover_state_t;

endpackage

// File: rtl/move_target.sv
// Combinational target computation: decodes one player's key nibble and
// produces the saturated candidate position plus a diagonal-move flag.
module move_target #(
    parameter int CW   = 11,
    parameter int XMAX = 768,
    parameter int YMAX = 568,
    parameter int STEP = 1
) (
    input  logic [3:0]           key,
    input  logic signed [CW-1:0] cur_x,
    input  logic signed [CW-1:0] cur_y,
    output logic signed [CW-1:0] tgt_x,
    output logic signed [CW-1:0] tgt_y,
    output logic                 diag
);
    import bomber_pkg::*;

    localparam logic signed [CW:0] STEP_W = (CW+1)'(STEP);
    localparam logic signed [CW:0] XMAX_W = (CW+1)'(XMAX);
    localparam logic signed [CW:0] YMAX_W = (CW+1)'(YMAX);

    logic go_r, go_l, go_d, go_u;
    logic signed [CW:0] dx, dy, sum_x, sum_y;

    always_comb begin
        go_r = ~key[KEY_RIGHT];
        go_l = ~key[KEY_LEFT];
        go_d = ~key[KEY_DOWN];
        go_u = ~key[KEY_UP];

        dx = '0;
        if (go_r && !go_l)
            dx = STEP_W;
        else if (go_l && !go_r)
            dx = -STEP_W;

        dy = '0;
        if (go_d && !go_u)
            dy = STEP_W;
        else if (go_u && !go_d)
            dy = -STEP_W;

        // One extra bit of headroom so the sum cannot wrap before clamping
        sum_x = {cur_x[CW-1], cur_x} + dx;
        sum_y = {cur_y[CW-1], cur_y} + dy;

        if (sum_x < 0)
            tgt_x = '0;
        else if (sum_x > XMAX_W)
            tgt_x = XMAX_W[CW-1:0];
        else
            tgt_x = sum_x[CW-1:0];

        if (sum_y < 0)
            tgt_y = '0;
        else if (sum_y > YMAX_W)
            tgt_y = YMAX_W[CW-1:0];
        else
            tgt_y = sum_y[CW-1:0];

        diag = (tgt_x != cur_x) && (tgt_y != cur_y);
    end

endmodule

// File: rtl/player_mover.sv
// Multi-player sprite position controller: once per update pass, walks the
// players in order, asks the external collision checker about each move and commits it.
module player_mover #(
    parameter int NPLAYERS        = 2,
    parameter int CW              = 11,
    parameter int HACTIVE         = bomber_pkg::HACTIVE,
    parameter int VACTIVE         = bomber_pkg::VACTIVE,
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 32,
    parameter int STEP            = 1,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     SOF,
    input  logic                     EOF,
    input  logic [4*NPLAYERS-1:0]    key,
    output logic [CW*NPLAYERS-1:0]   centerX,
    output logic [CW*NPLAYERS-1:0]   centerY,
    output logic                     query_req,
    output logic [CW-1:0]            query_x,
    output logic [CW-1:0]            query_y,
    output logic [1:0]               query_id,
    input  logic                     query_ack,
    input  logic                     query_blocked,
    output logic                     pass_overrun
);
    import bomber_pkg::*;

    localparam int XMAX = HACTIVE - SPRITE_W;
    localparam int YMAX = VACTIVE - SPRITE_H;
    localparam int PW   = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
    localparam int FCW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);
    localparam logic [PW-1:0]  PID_LAST = PW'(NPLAYERS - 1);

    mover_state_t state, state_n;

    logic                 blank;
    logic [FCW-1:0]       frame_cnt;
    logic [PW-1:0]        pid;
    logic [1:0]           attempt;
    logic                 abort_r;
    logic                 diag_r;
    logic signed [CW-1:0] pos_x [NPLAYERS];
    logic signed [CW-1:0] pos_y [NPLAYERS];
    logic signed [CW-1:0] cur_x, cur_y, tgt_x, tgt_y, cand_x, cand_y;

    logic [3:0]           key_sel;
    logic signed [CW-1:0] sel_x, sel_y, mt_x, mt_y;
    logic                 mt_diag;
    logic                 pass_start, cut, ack_seen;
    logic                 do_decode, do_issue, do_commit, do_retry, do_next, do_abort;

    always_comb begin
        key_sel = '1;
        sel_x   = '0;
        sel_y   = '0;
        for (int unsigned i = 0; i < NPLAYERS; i++) begin
            if (PW'(i) == pid) begin
                key_sel = key[4*i +: 4];
                sel_x   = pos_x[i];
                sel_y   = pos_y[i];
            end
        end
    end

    always_comb begin
        centerX = '0;
        centerY = '0;
        for (int unsigned i = 0; i < NPLAYERS; i++) begin
            centerX[CW*i +: CW] = pos_x[i];
            centerY[CW*i +: CW] = pos_y[i];
        end
    end

    move_target #(
        .CW   (CW),
        .XMAX (XMAX),
        .YMAX (YMAX),
        .STEP (STEP)
    ) u_move_target (
        .key   (key_sel),
        .cur_x (sel_x),
        .cur_y (sel_y),
        .tgt_x (mt_x),
        .tgt_y (mt_y),
        .diag  (mt_diag)
    );

    assign pass_start = EOF && (frame_cnt == FC_LAST);
    // blank already low means SOF arrived earlier in this pass
    assign cut        = SOF || !blank;
    assign ack_seen   = query_req && query_ack;

    always_comb begin
        state_n   = state;
        do_decode = 1'b0;
        do_issue  = 1'b0;
        do_commit = 1'b0;
        do_retry  = 1'b0;
        do_next   = 1'b0;
        do_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pass_start)
                    state_n = ST_DECODE;
            end
            ST_DECODE: begin
                if (cut) begin
                    do_abort = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    do_decode = 1'b1;
                    state_n   = (mt_x == sel_x && mt_y == sel_y) ? ST_NEXT : ST_QUERY;
                end
            end
            ST_QUERY: begin
                if (cut) begin
                    do_abort = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    do_issue = 1'b1;
                    state_n  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_seen) begin
                    if (abort_r || cut) begin
                        do_abort = 1'b1;
                        state_n  = ST_IDLE;
                    end else if (!query_blocked) begin
                        state_n = ST_COMMIT;
                    end else if (diag_r && attempt != 2'd2) begin
                        do_retry = 1'b1;
                        state_n  = ST_QUERY;
                    end else begin
                        state_n = ST_NEXT;
                    end
                end
            end
            ST_COMMIT: begin
                if (cut) begin
                    do_abort = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    do_commit = 1'b1;
                    state_n   = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (pid == PID_LAST) begin
                    do_next = 1'b1;
                    state_n = ST_IDLE;
                end else if (cut) begin
                    do_abort = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    do_next = 1'b1;
                    state_n = ST_DECODE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            blank        <= 1'b0;
            frame_cnt    <= '0;
            pid          <= '0;
            attempt      <= '0;
            abort_r      <= 1'b0;
            diag_r       <= 1'b0;
            cur_x        <= '0;
            cur_y        <= '0;
            tgt_x        <= '0;
            tgt_y        <= '0;
            cand_x       <= '0;
            cand_y       <= '0;
            query_req    <= 1'b0;
            query_x      <= '0;
            query_y      <= '0;
            query_id     <= '0;
            pass_overrun <= 1'b0;
            for (int unsigned i = 0; i < NPLAYERS; i++) begin
                pos_x[i] <= (i % 2 == 0) ? '0 : CW'(XMAX);
                pos_y[i] <= (i < 2)      ? '0 : CW'(YMAX);
            end
        end else begin
            state        <= state_n;
            pass_overrun <= do_abort;

            if (SOF)
                blank <= 1'b0;
            else if (EOF)
                blank <= 1'b1;

            if (EOF)
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FCW'(1);

            abort_r <= (state == ST_WAIT_ACK) && (abort_r || SOF);

            if (ack_seen)
                query_req <= 1'b0;

            if (do_decode) begin
                cur_x   <= sel_x;
                cur_y   <= sel_y;
                tgt_x   <= mt_x;
                tgt_y   <= mt_y;
                cand_x  <= mt_x;
                cand_y  <= mt_y;
                diag_r  <= mt_diag;
                attempt <= '0;
            end

            if (do_issue) begin
                query_req <= 1'b1;
                query_x   <= cand_x;
                query_y   <= cand_y;
                query_id  <= 2'(pid);
            end

            // Diagonal fallback order: slide along X first, then along Y
            if (do_retry) begin
                attempt <= attempt + 2'd1;
                if (attempt == 2'd0) begin
                    cand_x <= tgt_x;
                    cand_y <= cur_y;
                end else begin
                    cand_x <= cur_x;
                    cand_y <= tgt_y;
                end
            end

            if (do_commit) begin
                for (int unsigned i = 0; i < NPLAYERS; i++) begin
                    if (PW'(i) == pid) begin
                        pos_x[i] <= cand_x;
                        pos_y[i] <= cand_y;
                    end
                end
            end

            if (do_next)
                pid <= (pid == PID_LAST) ? '0 : pid + PW'(1);
            if (do_abort)
                pid <= '0;
        end
    end

endmodule
